// File: rtl/axis_upsizer_n_if.sv
// Bus bundle for the N:1 AXI-Stream upsizer: a narrow input stream and a wide output stream.
// The slave modport is the upsizer's view; master is the surrounding producer/consumer.
interface axis_upsizer_n_if #(
    parameter int W = 40,
    parameter int N = 4
);
    logic [W-1:0]   in_tdata;
    logic           in_tlast;
    logic           in_tvalid;
    logic           in_tready;
    logic [N*W-1:0] out_tdata;
    logic [N-1:0]   out_tkeep;
    logic           out_tlast;
    logic           out_tvalid;
    logic           out_tready;

    modport slave (
        input  in_tdata, in_tlast, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid
    );

    modport master (
        output in_tdata, in_tlast, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid
    );
endinterface

// File: rtl/axis_upsizer_n.sv
// Packs N consecutive W-bit beats into one N*W-bit beat, first beat in the top lane.
// in_tlast flushes a partial word early; out_tkeep marks the filled (top) lanes.
module axis_upsizer_n #(
    parameter int W = 40,
    parameter int N = 4
) (
    input logic            aclk,
    input logic            rst,
    axis_upsizer_n_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef logic [N-1:0][W-1:0] word_t;

    logic [CW-1:0] cnt_q, cnt_d;
    word_t         acc_q, acc_d;
    word_t         odata_q, odata_d;
    logic [N-1:0]  okeep_q, okeep_d;
    logic          olast_q, olast_d;
    logic          ovalid_q, ovalid_d;

    logic          in_hs;
    logic          complete;
    logic [CW-1:0] lane;
    logic [N-1:0]  fill;
    word_t         merged;

    // Ready only looks at the output slot, so no path from in_tvalid to in_tready.
    assign bus.in_tready = ~ovalid_q | bus.out_tready;
    assign in_hs         = bus.in_tvalid & bus.in_tready;
    assign complete      = (cnt_q == CW'(N - 1)) | bus.in_tlast;
    assign lane          = CW'(N - 1) - cnt_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            fill[i] = ((N - 1 - i) <= int'(cnt_q));
        end
        merged       = acc_q;
        merged[lane] = bus.in_tdata;
        // Lanes below the current one are never written yet; mask anyway so stale data cannot leak.
        for (int i = 0; i < N; i++) begin
            if (!fill[i]) begin
                merged[i] = '0;
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        odata_d  = odata_q;
        okeep_d  = okeep_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q & ~bus.out_tready;
        if (in_hs) begin
            if (complete) begin
                odata_d  = merged;
                okeep_d  = fill;
                olast_d  = bus.in_tlast;
                ovalid_d = 1'b1;
                cnt_d    = '0;
                acc_d    = '0;
            end else begin
                acc_d = merged;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            odata_q  <= '0;
            okeep_q  <= '0;
            olast_q  <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            odata_q  <= odata_d;
            okeep_q  <= okeep_d;
            olast_q  <= olast_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.out_tdata  = odata_q;
    assign bus.out_tkeep  = okeep_q;
    assign bus.out_tlast  = olast_q;
    assign bus.out_tvalid = ovalid_q;
endmodule

// File: tb/tb_axis_upsizer_n.sv
// Directed bench for axis_upsizer_n: an N=2 and an N=4 instance driven from one initial block.
// A negedge monitor logs output handshakes and checks ready/stability rules on the N=2 instance.
module tb_axis_upsizer_n;
    localparam int W = 40;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    always #5 aclk = ~aclk;

    axis_upsizer_n_if #(.W(W), .N(2)) if2 ();
    axis_upsizer_n_if #(.W(W), .N(4)) if4 ();

    axis_upsizer_n #(.W(W), .N(2)) dut2 (.aclk(aclk), .rst(rst), .bus(if2.slave));
    axis_upsizer_n #(.W(W), .N(4)) dut4 (.aclk(aclk), .rst(rst), .bus(if4.slave));

    int nvec = 0;
    int nerr = 0;

    logic [82:0]  q2[$];
    logic [164:0] q4[$];

    task automatic chk(input string tag, input logic [164:0] obs, input logic [164:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor
    logic        mon_en = 1'b0;
    logic        stall2 = 1'b0;
    logic [82:0] hold2  = '0;
    logic        exp_rdy2;
    always @(negedge aclk) begin
        if (mon_en && !rst) begin
            exp_rdy2 = ~if2.out_tvalid | if2.out_tready;
            chk("rdy_eq2", {164'b0, if2.in_tready}, {164'b0, exp_rdy2});
            if (stall2) begin
                chk("stable2", {81'b0, if2.out_tvalid, if2.out_tlast, if2.out_tkeep, if2.out_tdata},
                    {81'b0, 1'b1, hold2});
            end
            stall2 <= if2.out_tvalid & ~if2.out_tready;
            hold2  <= {if2.out_tlast, if2.out_tkeep, if2.out_tdata};
            if (if2.out_tvalid && if2.out_tready) q2.push_back({if2.out_tlast, if2.out_tkeep, if2.out_tdata});
            if (if4.out_tvalid && if4.out_tready) q4.push_back({if4.out_tlast, if4.out_tkeep, if4.out_tdata});
        end else begin
            stall2 <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send2(input logic [39:0] d, input logic l);
        logic hs;
        int   t;
        if2.in_tvalid = 1'b1;
        if2.in_tdata  = d;
        if2.in_tlast  = l;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 200) begin
            @(negedge aclk);
            hs = if2.in_tready;
            tick();
            t++;
        end
        if (!hs) chk("send2_timeout", {164'b0, hs}, {164'b0, 1'b1});
        if2.in_tvalid = 1'b0;
    endtask

    task automatic send4(input logic [39:0] d, input logic l);
        logic hs;
        int   t;
        if4.in_tvalid = 1'b1;
        if4.in_tdata  = d;
        if4.in_tlast  = l;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 200) begin
            @(negedge aclk);
            hs = if4.in_tready;
            tick();
            t++;
        end
        if (!hs) chk("send4_timeout", {164'b0, hs}, {164'b0, 1'b1});
        if4.in_tvalid = 1'b0;
    endtask

    function automatic logic [39:0] bp_beat(input int p, input int b);
        return {8'(8'hC0 + p), 24'h0, 8'(b)};
    endfunction

    initial begin
        logic [39:0] gb[8];
        logic [39:0] d0, d1, d2, d3;
        int          t;

        if2.in_tvalid = 0; if2.in_tdata = '0; if2.in_tlast = 0; if2.out_tready = 1;
        if4.in_tvalid = 0; if4.in_tdata = '0; if4.in_tlast = 0; if4.out_tready = 1;

        // Reset state
        #1;
        chk("rst_valid2", {164'b0, if2.out_tvalid}, 165'd0);
        chk("rst_data2",  {85'b0, if2.out_tdata}, 165'd0);
        chk("rst_keep4",  {161'b0, if4.out_tkeep}, 165'd0);
        chk("rst_last4",  {164'b0, if4.out_tlast}, 165'd0);
        chk("rst_rdy2",   {164'b0, if2.in_tready}, 165'd1);
        #21 rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Back-to-back N=2
        send2("ABCDE", 0);
        chk("b2b_v0", {164'b0, if2.out_tvalid}, 165'd0);
        chk("b2b_rdy0", {164'b0, if2.in_tready}, 165'd1);
        send2("FGHIJ", 0);
        chk("b2b_w0", {81'b0, if2.out_tvalid, if2.out_tlast, if2.out_tkeep, if2.out_tdata},
            {81'b0, 1'b1, 1'b0, 2'b11, "ABCDEFGHIJ"});
        send2("KLMNO", 0);
        chk("b2b_v2", {164'b0, if2.out_tvalid}, 165'd0);
        chk("b2b_rdy2", {164'b0, if2.in_tready}, 165'd1);
        send2("PQRST", 0);
        chk("b2b_w1", {81'b0, if2.out_tvalid, if2.out_tlast, if2.out_tkeep, if2.out_tdata},
            {81'b0, 1'b1, 1'b0, 2'b11, "KLMNOPQRST"});
        tick();
        chk("b2b_cnt", 165'(q2.size()), 165'd2);
        q2.delete();

        // Gaps N=4: valid toggles every cycle, junk data during gaps
        for (int i = 0; i < 8; i++) begin
            gb[i] = 40'hA0_0000_0000 + 40'(i * 17 + 3);
            send4(gb[i], 0);
            if4.in_tdata = {8'hEE, 32'($urandom)};
            tick();
        end
        tick(); tick();
        chk("gap_cnt", 165'(q4.size()), 165'd2);
        if (q4.size() >= 2) begin
            chk("gap_w0", q4[0], {1'b0, 4'hF, gb[0], gb[1], gb[2], gb[3]});
            chk("gap_w1", q4[1], {1'b0, 4'hF, gb[4], gb[5], gb[6], gb[7]});
        end
        q4.delete();

        // Partial flush, single-beat packet, full word with tlast
        send4("AAAAA", 0);
        send4("BBBBB", 0);
        send4("CCCCC", 1);
        chk("flush3", {1'b0, if4.out_tvalid, if4.out_tlast, if4.out_tkeep, if4.out_tdata},
            {1'b0, 1'b1, 1'b1, 4'b1110, "AAAAA", "BBBBB", "CCCCC", 40'h0});
        send4("DDDDD", 1);
        chk("single", {1'b0, if4.out_tvalid, if4.out_tlast, if4.out_tkeep, if4.out_tdata},
            {1'b0, 1'b1, 1'b1, 4'b1000, "DDDDD", 120'h0});
        send4("EEEEE", 0);
        send4("FFFFF", 0);
        send4("GGGGG", 0);
        send4("HHHHH", 1);
        chk("full_last", {1'b0, if4.out_tvalid, if4.out_tlast, if4.out_tkeep, if4.out_tdata},
            {1'b0, 1'b1, 1'b1, 4'b1111, "EEEEE", "FFFFF", "GGGGG", "HHHHH"});
        tick();
        chk("flush_cnt", 165'(q4.size()), 165'd3);
        q4.delete();

        // Backpressure N=2: 3 packets x 6 beats against a scripted out_tready
        q2.delete();
        fork
            begin
                for (int c = 0; c < 8; c++) begin if2.out_tready = 1; tick(); end
                for (int c = 0; c < 8; c++) begin if2.out_tready = 0; tick(); end
                for (int c = 0; c < 20; c++) begin if2.out_tready = 1'(c % 2); tick(); end
                for (int c = 0; c < 50; c++) begin if2.out_tready = 1'($urandom_range(0, 1)); tick(); end
                if2.out_tready = 1;
            end
            begin
                for (int p = 0; p < 3; p++)
                    for (int b = 0; b < 6; b++)
                        send2(bp_beat(p, b), b == 5);
            end
        join
        t = 0;
        while (q2.size() < 9 && t < 1000) begin tick(); t++; end
        chk("bp_cnt", 165'(q2.size()), 165'd9);
        if (q2.size() == 9) begin
            for (int p = 0; p < 3; p++)
                for (int w = 0; w < 3; w++)
                    chk($sformatf("bp_p%0d_w%0d", p, w), {82'b0, q2[p * 3 + w]},
                        {82'b0, w == 2, 2'b11, bp_beat(p, 2 * w), bp_beat(p, 2 * w + 1)});
        end
        q2.delete();

        // Reset mid-word: dut2 holds a pending word, dut4 holds two lanes
        if2.out_tready = 0;
        send2("xxxx1", 0);
        send2("xxxx2", 0);
        chk("pre_rst_v2", {164'b0, if2.out_tvalid}, 165'd1);
        send4("yyyy1", 0);
        send4("yyyy2", 0);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_v2", {164'b0, if2.out_tvalid}, 165'd0);
        chk("mid_rst_d2", {85'b0, if2.out_tdata}, 165'd0);
        chk("mid_rst_r2", {164'b0, if2.in_tready}, 165'd1);
        chk("mid_rst_v4", {164'b0, if4.out_tvalid}, 165'd0);
        #2 rst = 1'b0;
        tick();
        q2.delete();
        q4.delete();
        if2.out_tready = 1;
        d0 = "zzzz0"; d1 = "zzzz1"; d2 = "zzzz2"; d3 = "zzzz3";
        send4(d0, 0);
        send4(d1, 0);
        send4(d2, 0);
        send4(d3, 0);
        chk("post_rst4", {1'b0, if4.out_tvalid, if4.out_tlast, if4.out_tkeep, if4.out_tdata},
            {1'b0, 1'b1, 1'b0, 4'hF, d0, d1, d2, d3});
        send2("qqqqq", 1);
        chk("post_rst2", {81'b0, if2.out_tvalid, if2.out_tlast, if2.out_tkeep, if2.out_tdata},
            {81'b0, 1'b1, 1'b1, 2'b10, "qqqqq", 40'h0});
        tick();
        chk("post_rst_q2", 165'(q2.size()), 165'd1);
        chk("post_rst_q4", 165'(q4.size()), 165'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
